// File: rtl/pwm_cmd_scheduler.sv
// Frame capture FIFO plus address decoder that turns SPI frames into single-cycle PWM/divider write strobes.
// Define PWM_SYNC_UPDATE_EN to hold channel/broadcast writes until the next PWM period_start pulse.
module pwm_cmd_scheduler #(
    parameter int  FIFO_DEPTH = 4,
    parameter int  DATA_W     = 8,
    parameter int  NUM_CH     = 8,
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       frame_in_i,
    input  logic              frame_rdy_i,
    input  logic              period_start_i,
    input  logic              clear_err_i,
    output logic [DATA_W-1:0] wr_data_o,
    output logic [NUM_CH-1:0] pwm_wr_o,
    output logic              clk_div_wr_o,
    output logic              busy_o,
    output logic [LVL_W-1:0]  fifo_level_o,
    output logic              overflow_o,
    output logic              bad_addr_o
);

`ifdef PWM_SYNC_UPDATE_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CHECK = 2'd1, S_STROBE = 2'd2, S_WAIT = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CHECK = 2'd1, S_STROBE = 2'd2} state_t;
`endif

    logic [15:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  count_q;
    logic              rdy_prev_q;
    logic [15:0]       cmd_q;
    state_t            state_q, state_d;
    logic [NUM_CH-1:0] pwm_wr_q, pwm_wr_d;
    logic              div_wr_q, div_wr_d;
    logic              overflow_q, bad_addr_q;

    logic              push, pop, push_ok, drop, full, empty, bad_set;
    logic [3:0]        addr;
    logic [NUM_CH-1:0] ch_mask;
    logic              ch_hit, is_div;
    logic              unused_ok;

    assign push    = frame_rdy_i & ~rdy_prev_q;
    assign full    = (count_q == LVL_W'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign pop     = (state_q == S_IDLE) && !empty;
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;

    assign addr   = cmd_q[15:12];
    assign is_div = (addr == 4'd8);
    assign ch_hit = |ch_mask;

    // Broadcast (address 15) simply sets every bit of the channel mask.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_mask
        assign ch_mask[gi] = (addr == 4'hF) || (addr == 4'(gi));
    end

    always_comb begin
        state_d  = state_q;
        pwm_wr_d = '0;
        div_wr_d = 1'b0;
        bad_set  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (is_div) begin
                    state_d  = S_STROBE;
                    div_wr_d = 1'b1;
                end else if (ch_hit) begin
`ifdef PWM_SYNC_UPDATE_EN
                    state_d  = S_WAIT;
`else
                    state_d  = S_STROBE;
                    pwm_wr_d = ch_mask;
`endif
                end else begin
                    bad_set = 1'b1;
                    state_d = S_IDLE;
                end
            end
`ifdef PWM_SYNC_UPDATE_EN
            S_WAIT: begin
                if (period_start_i) begin
                    state_d  = S_STROBE;
                    pwm_wr_d = ch_mask;
                end
            end
`endif
            S_STROBE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Storage is left unreset so it maps onto plain RAM; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= frame_in_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_prev_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            cmd_q      <= '0;
            state_q    <= S_IDLE;
            pwm_wr_q   <= '0;
            div_wr_q   <= 1'b0;
            overflow_q <= 1'b0;
            bad_addr_q <= 1'b0;
        end else begin
            rdy_prev_q <= frame_rdy_i;
            state_q    <= state_d;
            pwm_wr_q   <= pwm_wr_d;
            div_wr_q   <= div_wr_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                cmd_q    <= mem_q[rd_ptr_q];
            end
            if (push_ok && !pop)      count_q <= count_q + LVL_W'(1);
            else if (!push_ok && pop) count_q <= count_q - LVL_W'(1);
            // A new error in the same cycle as clear_err keeps the flag set.
            if (drop)             overflow_q <= 1'b1;
            else if (clear_err_i) overflow_q <= 1'b0;
            if (bad_set)          bad_addr_q <= 1'b1;
            else if (clear_err_i) bad_addr_q <= 1'b0;
        end
    end

    assign unused_ok    = ^{cmd_q[11:0], period_start_i};
    assign wr_data_o    = cmd_q[DATA_W-1:0];
    assign pwm_wr_o     = pwm_wr_q;
    assign clk_div_wr_o = div_wr_q;
    assign busy_o       = (state_q != S_IDLE) || !empty;
    assign fifo_level_o = count_q;
    assign overflow_o   = overflow_q;
    assign bad_addr_o   = bad_addr_q;

endmodule

// File: tb/tb_pwm_cmd_scheduler.sv
// Directed bench for pwm_cmd_scheduler with a strobe scoreboard; sync-specific steps follow PWM_SYNC_UPDATE_EN.
module tb_pwm_cmd_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] frame_in;
    logic        frame_rdy, period_start, clear_err;
    logic [7:0]  wr_data;
    logic [7:0]  pwm_wr;
    logic        clk_div_wr, busy, overflow, bad_addr;
    logic [2:0]  fifo_level;

    typedef struct {
        logic [7:0] mask;
        logic       div;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    pwm_cmd_scheduler dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .frame_in_i     (frame_in),
        .frame_rdy_i    (frame_rdy),
        .period_start_i (period_start),
        .clear_err_i    (clear_err),
        .wr_data_o      (wr_data),
        .pwm_wr_o       (pwm_wr),
        .clk_div_wr_o   (clk_div_wr),
        .busy_o         (busy),
        .fifo_level_o   (fifo_level),
        .overflow_o     (overflow),
        .bad_addr_o     (bad_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected strobe from the address map: channels 0..7, divider 8, broadcast 15, others silent.
    task automatic expect_frame(input logic [15:0] f);
        exp_t e;
        e.mask = '0;
        e.div  = 1'b0;
        e.data = f[7:0];
        if (f[15:12] < 4'd8) begin
            e.mask = 8'(1) << f[15:12];
            sb.push_back(e);
        end else if (f[15:12] == 4'd8) begin
            e.div = 1'b1;
            sb.push_back(e);
        end else if (f[15:12] == 4'hF) begin
            e.mask = 8'hFF;
            sb.push_back(e);
        end
    endtask

    task automatic send(input logic [15:0] f);
        frame_in  = f;
        frame_rdy = 1'b1;
        expect_frame(f);
        tick();
        frame_rdy = 1'b0;
        tick();
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60 && busy; i++) begin
            period_start = 1'b1;
            tick();
            period_start = 1'b0;
            tick();
            tick();
        end
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && (pwm_wr !== 8'h00 || clk_div_wr !== 1'b0)) begin
            chk("strobe_exclusive", (pwm_wr != 8'h00) && clk_div_wr, 0);
            if (sb.size() == 0) begin
                chk("unexpected_strobe", {pwm_wr, clk_div_wr}, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("strobe_mask", pwm_wr, mon_e.mask);
                chk("strobe_div", clk_div_wr, mon_e.div);
                chk("strobe_data", wr_data, mon_e.data);
                $display("strobe pwm_wr=%02h clk_div_wr=%0b wr_data=%02h", pwm_wr, clk_div_wr, wr_data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; frame_in = '0; frame_rdy = 1'b0; period_start = 1'b0; clear_err = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("rst_pwm_wr", pwm_wr, 0);
        chk("rst_div_wr", clk_div_wr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_bad_addr", bad_addr, 0);
        chk("rst_wr_data", wr_data, 0);

        // Single channel write with frame_rdy held for 10 cycles.
        frame_in = 16'h30A5; frame_rdy = 1'b1; expect_frame(frame_in);
        tick();
        chk("t1_e0_pwm", pwm_wr, 0);
        chk("t1_e0_level", fifo_level, 1);
        tick();
        chk("t1_e1_pwm", pwm_wr, 0);
        chk("t1_e1_data", wr_data, 8'hA5);
        chk("t1_e1_level", fifo_level, 0);
        tick();
`ifndef PWM_SYNC_UPDATE_EN
        chk("t1_e2_pwm", pwm_wr, 8'h08);
        chk("t1_e2_data", wr_data, 8'hA5);
        tick();
        chk("t1_e3_pwm", pwm_wr, 0);
`else
        chk("t1_wait_pwm", pwm_wr, 0);
        tick();
        chk("t1_wait_busy", busy, 1);
`endif
        repeat (6) tick();
        frame_rdy = 1'b0;
        tick();
        drain("t1");
        chk("t1_level_end", fifo_level, 0);

        // Broadcast and divider.
        send(16'hF040);
        drain("t2_bcast");
        send(16'h8003);
        drain("t2_div");

        // Unmapped address and sticky flag handling.
        send(16'hA011);
        drain("t3");
        chk("t3_bad_addr", bad_addr, 1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("t3_bad_cleared", bad_addr, 0);
        frame_in = 16'hB000; frame_rdy = 1'b1;
        tick();
        frame_rdy = 1'b0;
        tick();
        clear_err = 1'b1;
        tick();
        chk("t3_set_wins", bad_addr, 1);
        tick();
        chk("t3_clear_after", bad_addr, 0);
        clear_err = 1'b0;

        // Divider frames every 2 cycles outrun the 3-cycle drain; the 13th finds the FIFO full.
        for (int i = 0; i < 13; i++) begin
            frame_in  = 16'h8000 | 16'(8'h10 + i);
            frame_rdy = 1'b1;
            if (i != 12) expect_frame(frame_in);
            tick();
            frame_rdy = 1'b0;
            tick();
        end
        chk("t4_overflow", overflow, 1);
        chk("t4_level", fifo_level, 3);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("t4_overflow_cleared", overflow, 0);
        drain("t4");

        // Channel write with a period_start pulse coinciding with entry into WAIT.
        frame_in = 16'h1080; frame_rdy = 1'b1; expect_frame(frame_in);
        tick();
        frame_rdy = 1'b0;
        tick();
        period_start = 1'b1;
        tick();
        period_start = 1'b0;
`ifndef PWM_SYNC_UPDATE_EN
        chk("t5_nosync_pwm", pwm_wr, 8'h02);
`else
        chk("t5_entry_pulse_ignored", pwm_wr, 0);
        repeat (4) tick();
        chk("t5_held_pwm", pwm_wr, 0);
        chk("t5_held_busy", busy, 1);
        period_start = 1'b1;
        tick();
        period_start = 1'b0;
        chk("t5_sync_pwm", pwm_wr, 8'h02);
`endif
        tick();
        chk("t5_pwm_low", pwm_wr, 0);
        drain("t5");
        frame_in = 16'h8002; frame_rdy = 1'b1; expect_frame(frame_in);
        tick();
        frame_rdy = 1'b0;
        tick();
        tick();
        chk("t5_div_strobe", clk_div_wr, 1);
        chk("t5_div_pwm", pwm_wr, 0);
        chk("t5_div_data", wr_data, 8'h02);
        drain("t5_div");

`ifdef PWM_SYNC_UPDATE_EN
        // Six channel frames while stalled in WAIT: 1 in service, 4 queued, 1 dropped.
        for (int i = 0; i < 6; i++) begin
            frame_in  = {4'(i), 4'h0, 8'(8'hB0 + i)};
            frame_rdy = 1'b1;
            if (i < 5) expect_frame(frame_in);
            tick();
            frame_rdy = 1'b0;
            tick();
        end
        chk("t6_level", fifo_level, 4);
        chk("t6_overflow", overflow, 1);
        drain("t6");
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
`endif

        // Reset with commands in flight aborts them.
        for (int i = 0; i < 4; i++) begin
            frame_in  = {4'd2, 4'h0, 8'(8'hC0 + i)};
            frame_rdy = 1'b1;
            expect_frame(frame_in);
            tick();
            frame_rdy = 1'b0;
            tick();
        end
`ifdef PWM_SYNC_UPDATE_EN
        chk("t7_level_before", fifo_level, 3);
`endif
        #2 rst_n = 1'b0;
        #1;
        chk("t7_rst_pwm", pwm_wr, 0);
        chk("t7_rst_div", clk_div_wr, 0);
        chk("t7_rst_level", fifo_level, 0);
        chk("t7_rst_busy", busy, 0);
        sb.delete();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            period_start = 1'b1;
            tick();
            period_start = 1'b0;
            tick();
        end
        chk("t7_post_level", fifo_level, 0);
        chk("t7_post_busy", busy, 0);
        chk("final_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
